// File: rtl/benes_4_route_pkg.sv
// ---------------------------------------------------------------------------
// benes_4_route_pkg
// Shared definitions for the 4-port Benes routing pipeline:
//   - network geometry (port count, column count)
//   - sw_cfg_t : the six switch-setting bits that travel with every beat
//   - LINK_SRC : inter-column wiring, expressed as "input lane j of the next
//                column is fed by output lane LINK_SRC[k][j] of column k"
//   - sw_bit() : picks one switch setting out of a sw_cfg_t record
// Lane numbering: switch r of a column owns lanes 2r (upper) and 2r+1 (lower).
// ---------------------------------------------------------------------------
package benes_4_route_pkg;

    localparam int N_PORTS = 32'sd4;
    localparam int N_COLS  = 32'sd3;
    localparam int N_ROWS  = 32'sd2;

    // Switch settings for one beat: s_<row>_<column>, 1 = straight, 0 = cross.
    typedef struct packed {
        logic s_0_0;
        logic s_0_1;
        logic s_0_2;
        logic s_1_0;
        logic s_1_1;
        logic s_1_2;
    } sw_cfg_t;

    // Both links use the same pattern: switch s output p lands on switch p
    // input s, i.e. the two index bits are swapped. The table is its own
    // inverse, so it reads equally well as a source or a destination map.
    localparam logic [1:0] LINK_SRC [2][4] = '{
        '{2'd0, 2'd2, 2'd1, 2'd3},   // column 0 -> column 1
        '{2'd0, 2'd2, 2'd1, 2'd3}    // column 1 -> column 2
    };

    // Select the setting of the switch at (row, col) from a record.
    function automatic logic sw_bit(input sw_cfg_t cfg, input logic row, input logic [1:0] col);
        logic b;
        case ({row, col})
            3'b0_00: b = cfg.s_0_0;
            3'b0_01: b = cfg.s_0_1;
            3'b0_10: b = cfg.s_0_2;
            3'b1_00: b = cfg.s_1_0;
            3'b1_01: b = cfg.s_1_1;
            3'b1_10: b = cfg.s_1_2;
            default: b = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/benes_2x2_switch.sv
// ---------------------------------------------------------------------------
// benes_2x2_switch
// Combinational 2x2 exchange element.
//   a_upper, a_lower : input lanes (DATA_W each)
//   straight         : 1 = pass through, 0 = exchange the two lanes
//   y_upper, y_lower : output lanes
// ---------------------------------------------------------------------------
module benes_2x2_switch
    import benes_4_route_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_upper,
    input  logic [DATA_W-1:0] a_lower,
    input  logic              straight,
    output logic [DATA_W-1:0] y_upper,
    output logic [DATA_W-1:0] y_lower
);

    // Pass or exchange the two lanes.
    always_comb begin
        y_upper = a_upper;
        y_lower = a_lower;
        if (straight) begin
            y_upper = a_upper;
            y_lower = a_lower;
        end else begin
            y_upper = a_lower;
            y_lower = a_upper;
        end
    end

endmodule

// File: rtl/benes_4_route.sv
// ---------------------------------------------------------------------------
// benes_4_route
// 4-port, 3-column Benes network with one register stage per column and a
// valid/ready handshake on both sides.
//   clk, rst                : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     : input beat handshake
//   in_data0..3             : input lanes
//   state_<r>_<c>           : switch settings for the beat being offered
//   out_valid / out_ready   : output beat handshake
//   out_data0..3            : routed lanes (registered)
//   beat_cnt                : wrapping count of delivered beats
// Each beat carries its own six settings down the pipe, so consecutive beats
// may be routed differently. Stage S1 holds column-0 results, S2 column-1,
// S3 column-2; S3 drives the outputs directly.
// ---------------------------------------------------------------------------
module benes_4_route
    import benes_4_route_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    input  logic              state_0_0,
    input  logic              state_0_1,
    input  logic              state_0_2,
    input  logic              state_1_0,
    input  logic              state_1_1,
    input  logic              state_1_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [15:0]       beat_cnt
);

    sw_cfg_t in_cfg_s;
    sw_cfg_t s1_cfg_r;
    sw_cfg_t s2_cfg_r;

    logic [N_PORTS-1:0][DATA_W-1:0] c0_in_s;
    logic [N_PORTS-1:0][DATA_W-1:0] c0_out_s;
    logic [N_PORTS-1:0][DATA_W-1:0] c1_in_s;
    logic [N_PORTS-1:0][DATA_W-1:0] c1_out_s;
    logic [N_PORTS-1:0][DATA_W-1:0] c2_in_s;
    logic [N_PORTS-1:0][DATA_W-1:0] c2_out_s;
    logic [N_PORTS-1:0][DATA_W-1:0] s1_data_r;
    logic [N_PORTS-1:0][DATA_W-1:0] s2_data_r;
    logic [N_PORTS-1:0][DATA_W-1:0] s3_data_r;

    logic        s1_valid_r;
    logic        s2_valid_r;
    logic        s3_valid_r;
    logic        rdy1_s;
    logic        rdy2_s;
    logic        rdy3_s;
    logic [15:0] beat_cnt_r;

    assign in_cfg_s = '{s_0_0: state_0_0, s_0_1: state_0_1, s_0_2: state_0_2,
                        s_1_0: state_1_0, s_1_1: state_1_1, s_1_2: state_1_2};

    assign c0_in_s = {in_data3, in_data2, in_data1, in_data0};

    // A stage can take a new beat when it is empty or its contents move on
    // this cycle; an empty stage therefore fills even behind a stall.
    assign rdy3_s   = !s3_valid_r || out_ready;
    assign rdy2_s   = !s2_valid_r || rdy3_s;
    assign rdy1_s   = !s1_valid_r || rdy2_s;
    assign in_ready = rdy1_s;

    // Inter-column wiring taken from the shared link tables.
    for (genvar j = 0; j < N_PORTS; j++) begin : g_link
        assign c1_in_s[j] = s1_data_r[LINK_SRC[0][j]];
        assign c2_in_s[j] = s2_data_r[LINK_SRC[1][j]];
    end

    // Column c switches use the settings captured with the beat they see:
    // column 0 the incoming beat, columns 1/2 the S1/S2 copies.
    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
        benes_2x2_switch #(.DATA_W(DATA_W)) u_sw_c0 (
            .a_upper  (c0_in_s[2*r]),
            .a_lower  (c0_in_s[2*r+1]),
            .straight (sw_bit(in_cfg_s, 1'(r), 2'd0)),
            .y_upper  (c0_out_s[2*r]),
            .y_lower  (c0_out_s[2*r+1])
        );
        benes_2x2_switch #(.DATA_W(DATA_W)) u_sw_c1 (
            .a_upper  (c1_in_s[2*r]),
            .a_lower  (c1_in_s[2*r+1]),
            .straight (sw_bit(s1_cfg_r, 1'(r), 2'd1)),
            .y_upper  (c1_out_s[2*r]),
            .y_lower  (c1_out_s[2*r+1])
        );
        benes_2x2_switch #(.DATA_W(DATA_W)) u_sw_c2 (
            .a_upper  (c2_in_s[2*r]),
            .a_lower  (c2_in_s[2*r+1]),
            .straight (sw_bit(s2_cfg_r, 1'(r), 2'd2)),
            .y_upper  (c2_out_s[2*r]),
            .y_lower  (c2_out_s[2*r+1])
        );
    end

    // Stage valid flags and the delivered-beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            s3_valid_r <= 1'b0;
            beat_cnt_r <= 16'd0;
        end else begin
            if (rdy1_s) begin
                s1_valid_r <= in_valid;
            end
            if (rdy2_s) begin
                s2_valid_r <= s1_valid_r;
            end
            if (rdy3_s) begin
                s3_valid_r <= s2_valid_r;
            end
            if (s3_valid_r && out_ready) begin
                beat_cnt_r <= beat_cnt_r + 16'd1;
            end
        end
    end

    // Stage payload and settings; only a valid beat overwrites a stage, so
    // idle-cycle inputs never disturb held data.
    always_ff @(posedge clk) begin
        if (rdy1_s && in_valid) begin
            s1_data_r <= c0_out_s;
            s1_cfg_r  <= in_cfg_s;
        end
        if (rdy2_s && s1_valid_r) begin
            s2_data_r <= c1_out_s;
            s2_cfg_r  <= s1_cfg_r;
        end
        if (rdy3_s && s2_valid_r) begin
            s3_data_r <= c2_out_s;
        end
    end

    assign out_valid = s3_valid_r;
    assign out_data0 = s3_data_r[0];
    assign out_data1 = s3_data_r[1];
    assign out_data2 = s3_data_r[2];
    assign out_data3 = s3_data_r[3];
    assign beat_cnt  = beat_cnt_r;

endmodule

// File: tb/tb_benes_4_route.sv
// ---------------------------------------------------------------------------
// tb_benes_4_route
// Directed and randomized checks of benes_4_route against a lane-level
// reference model (pairwise exchange per column, index-bit swap between
// columns) with an in-order scoreboard.
// ---------------------------------------------------------------------------
module tb_benes_4_route;

    localparam int DW = 8;
    typedef logic [3:0][DW-1:0] lanes_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data0, in_data1, in_data2, in_data3;
    logic          state_0_0, state_0_1, state_0_2, state_1_0, state_1_1, state_1_2;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [15:0]   beat_cnt;

    lanes_t out_s;
    assign out_s = {out_data3, out_data2, out_data1, out_data0};

    int     checks = 0;
    int     errors = 0;
    lanes_t exp_q[$];
    lanes_t held;
    logic   hold_prev;
    int     delivered;
    int     accepted;

    benes_4_route #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .state_0_0(state_0_0), .state_0_1(state_0_1), .state_0_2(state_0_2),
        .state_1_0(state_1_0), .state_1_1(state_1_1), .state_1_2(state_1_2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
        .beat_cnt(beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference routing. b[r*3+c] is the setting of switch row r, column c.
    function automatic lanes_t model_route(input lanes_t lanes, input logic [5:0] b);
        logic [DW-1:0] cur [4];
        logic [DW-1:0] nxt [4];
        logic [DW-1:0] t;
        lanes_t res;
        for (int k = 0; k < 4; k++) cur[k] = lanes[k];
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (b[r*3+c] == 1'b0) begin
                    t = cur[2*r];
                    cur[2*r] = cur[2*r+1];
                    cur[2*r+1] = t;
                end
            end
            if (c < 2) begin
                // output p of switch s goes to input s of switch p
                for (int src = 0; src < 4; src++) nxt[2*(src%2) + src/2] = cur[src];
                for (int k = 0; k < 4; k++) cur[k] = nxt[k];
            end
        end
        for (int k = 0; k < 4; k++) res[k] = cur[k];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1 ns later, and book the
    // handshakes that the coming rising edge will perform.
    task automatic cycle(input logic iv, input lanes_t d, input logic [5:0] b, input logic ordy);
        lanes_t e;
        @(negedge clk);
        in_valid  = iv;
        in_data0  = d[0]; in_data1 = d[1]; in_data2 = d[2]; in_data3 = d[3];
        state_0_0 = b[0]; state_0_1 = b[1]; state_0_2 = b[2];
        state_1_0 = b[3]; state_1_1 = b[4]; state_1_2 = b[5];
        out_ready = ordy;
        #1;
        if (hold_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_stable", 64'(out_s), 64'(held));
        end
        if (out_valid && out_ready) begin
            chk("sb_underflow", 64'(exp_q.size() == 0), 64'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("route", 64'(out_s), 64'(e));
            end
            delivered++;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model_route(d, b));
            accepted++;
        end
        hold_prev = out_valid && !out_ready;
        held = out_s;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, lanes_t'($urandom), 6'($urandom), 1'b1);
            lat = i + 1;
            if (out_valid === 1'b1) break;
        end
        chk("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() > 0; i++)
            cycle(1'b0, lanes_t'($urandom), 6'($urandom), 1'b1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        cycle(1'b0, lanes_t'($urandom), 6'($urandom), 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        hold_prev = 1'b0;
        delivered = 0;
        accepted = 0;
        #1;
    endtask

    initial begin : stim
        lanes_t x;
        lanes_t perm;
        int     lat;
        logic [5:0] found;
        logic   ok;
        int     guard;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        {in_data0, in_data1, in_data2, in_data3} = '0;
        {state_0_0, state_0_1, state_0_2, state_1_0, state_1_1, state_1_2} = 6'h3f;
        hold_prev = 1'b0; delivered = 0; accepted = 0;
        x = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // Reset state
        apply_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // All straight: identity, 3-cycle latency
        cycle(1'b1, x, 6'h3f, 1'b1);
        wait_out(lat);
        chk("latency", 64'(lat), 64'd3);
        chk("straight", 64'(out_s), 64'({8'hD3, 8'hC2, 8'hB1, 8'hA0}));

        // Settings 1,1,1,0,0,0 -> A0,C2,B1,D3
        cycle(1'b1, x, 6'b000111, 1'b1);
        wait_out(lat);
        chk("cfg_111000", 64'(out_s), 64'({8'hD3, 8'hB1, 8'hC2, 8'hA0}));

        // Settings 1,1,1,1,1,0 -> A0,B1,D3,C2
        cycle(1'b1, x, 6'b011111, 1'b1);
        wait_out(lat);
        chk("cfg_111110", 64'(out_s), 64'({8'hC2, 8'hD3, 8'hB1, 8'hA0}));
        drain();

        // All 24 destination-tag permutations
        for (int code = 0; code < 256; code++) begin
            for (int i = 0; i < 4; i++) perm[i] = 8'((code >> (2*i)) & 3);
            ok = (perm[0] != perm[1]) && (perm[0] != perm[2]) && (perm[0] != perm[3]) &&
                 (perm[1] != perm[2]) && (perm[1] != perm[3]) && (perm[2] != perm[3]);
            if (ok) begin
                found = 6'h3f;
                ok = 1'b0;
                for (int s = 0; s < 64 && !ok; s++) begin
                    if (model_route(perm, 6'(s)) == lanes_t'({8'd3, 8'd2, 8'd1, 8'd0})) begin
                        found = 6'(s);
                        ok = 1'b1;
                    end
                end
                chk("perm_cfg_found", 64'(ok), 64'd1);
                cycle(1'b1, perm, found, 1'b1);
                wait_out(lat);
                chk("perm_dest", 64'(out_s), 64'({8'd3, 8'd2, 8'd1, 8'd0}));
            end
        end
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 9) < 7), lanes_t'($urandom), 6'($urandom), 1'($urandom));
        drain();
        chk("rand_beat_cnt", 64'(beat_cnt), 64'(delivered & 16'hFFFF));
        chk("rand_in_eq_out", 64'(delivered), 64'(accepted));

        // Full pipe held for 5 cycles, then released
        for (int i = 0; i < 3; i++) cycle(1'b1, lanes_t'($urandom), 6'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, lanes_t'($urandom), 6'($urandom), 1'b0);
            chk("full_in_ready", 64'(in_ready), 64'd0);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, lanes_t'($urandom), 6'($urandom), 1'b1);
            chk("full_release_valid", 64'(out_valid), 64'd1);
        end
        drain();

        // Reset with two beats in flight
        for (int i = 0; i < 2; i++) cycle(1'b1, lanes_t'($urandom), 6'($urandom), 1'b0);
        apply_reset();
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_beat_cnt", 64'(beat_cnt), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, lanes_t'($urandom), 6'($urandom), 1'b1);
            chk("mid_rst_no_valid", 64'(out_valid), 64'd0);
        end
        cycle(1'b1, x, 6'h3f, 1'b1);
        wait_out(lat);
        chk("post_rst_latency", 64'(lat), 64'd3);
        drain();

        // Counter wrap: reach 0xFFFF deliveries, then one more
        apply_reset();
        guard = 0;
        while (delivered < 65535 && guard < 70000) begin
            cycle(1'(accepted < 65535), lanes_t'($urandom), 6'($urandom), 1'b1);
            guard++;
        end
        drain();
        chk("cnt_ffff", 64'(beat_cnt), 64'hFFFF);
        cycle(1'b1, x, 6'h3f, 1'b1);
        wait_out(lat);
        drain();
        chk("cnt_wrap", 64'(beat_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/benes_4_route.md
BENES_4_ROUTE -- requirements
Module: benes_4_route

Interface
REQ-001 Parameter: DATA_W, default 8, width of each data lane.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  input beat present.
REQ-006 in_ready  out  1  block accepts the beat this cycle.
REQ-007 in_data0..in_data3  in  DATA_W each  lane payloads.
REQ-008 state_0_0, state_0_1, state_0_2, state_1_0, state_1_1, state_1_2  in  1 each  switch settings for this beat.
  - state_<r>_<c>: r = switch row (0 = ports 0/1, 1 = ports 2/3), c = column 0..2.
REQ-009 out_valid  out  1  output beat present.
REQ-010 out_ready  in  1  downstream accepts the beat.
REQ-011 out_data0..out_data3  out  DATA_W each  routed payloads.
REQ-012 beat_cnt  out  16  count of beats delivered (out_valid && out_ready).

Function
REQ-013 Each switch SHALL pass straight when its bit is 1 (upper->upper, lower->lower) and cross when it is 0.
REQ-014 Column 0 switch r SHALL take lanes 2r (upper) and 2r+1 (lower).
REQ-015 Column 0 to column 1 wiring SHALL be:
  - sw0.upper -> M0.upper, sw0.lower -> M1.upper
  - sw1.upper -> M0.lower, sw1.lower -> M1.lower
REQ-016 Column 1 to column 2 wiring SHALL use the same pattern as REQ-015.
REQ-017 Column 2 switch r SHALL drive out_data(2r) (upper) and out_data(2r+1) (lower).
REQ-018 All six state bits SHALL be captured with the beat and travel with it; column c SHALL use the bits captured with the beat it is switching.
  - Beats with different settings MAY occupy the pipeline at the same time.
REQ-019 Pipeline: three register stages S1/S2/S3, one per column.
  - S3 registers drive out_data and out_valid.
  - Latency: 3 cycles from acceptance to out_valid with out_ready held high.
REQ-020 Stage readiness:
  - rdy3 = !v3 || out_ready
  - rdy2 = !v2 || rdy3
  - rdy1 = !v1 || rdy2
  - in_ready = rdy1
REQ-021 A stage SHALL load when its ready is high; it SHALL hold data and valid otherwise.
  - Throughput: one beat per cycle.
  - No beat is dropped or duplicated under any out_ready pattern.
REQ-022 Bubbles SHALL collapse: an invalid stage accepts a new beat even while a later stage stalls.
REQ-023 out_data SHALL remain stable while out_valid && !out_ready.
REQ-024 beat_cnt SHALL increment by 1 per delivered beat and wrap from 0xFFFF to 0.
REQ-025 in_data and state bits SHALL be ignored when in_valid is 0.

Reset
REQ-026 On rst: v1, v2, v3 and out_valid SHALL be 0, and beat_cnt SHALL be 0.
  - Data registers need no reset value; out_data is don't-care while out_valid = 0.
REQ-027 rst asserted mid-stream SHALL discard all in-flight beats.
  - in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-028 A shared package SHALL hold:
  - the port count (4) and column count (3) constants
  - the switch-setting record type (six bits)
  - the inter-column wiring tables
REQ-029 One sub-module, benes_2x2_switch (combinational 2x2 mux, DATA_W wide), SHALL be instantiated six times; stage registers live in the top level.

Verification
REQ-030 Inputs in_data = {A0,B1,C2,D3}, all bits 1, out_ready = 1 -> out_data = {A0,B1,C2,D3} exactly 3 cycles after acceptance.
REQ-031 Inputs {A0,B1,C2,D3}, bits (0_0..0_2, 1_0..1_2) = 1,1,1,0,0,0 -> out_data = {A0,C2,B1,D3}.
  - Same inputs, bits 1,1,1,1,1,0 -> out_data = {A0,B1,D3,C2}.
REQ-032 Exhaustive check over all 24 destination-tag permutations with their controller settings:
  - payload = destination index
  - each out_dataN must equal N for every case.
REQ-033 Back-to-back beats with different settings, plus random out_ready (about 50%) -> every beat arrives in order and correctly routed.
  - out_data stable during stalls.
  - beat_cnt equals the number of beats delivered.
REQ-034 Pipeline full (3 beats in flight), out_ready = 0 for 5 cycles:
  - in_ready = 0 throughout
  - then out_ready = 1 -> three beats delivered on consecutive cycles.
REQ-035 Apply rst with 2 beats in flight -> no out_valid afterwards until a new beat is accepted.
  - beat_cnt = 0 after reset.
  - Separately, force beat_cnt to 0xFFFF, deliver one beat -> beat_cnt = 0.
